// File: rtl/stream_arb_pkg.sv
// Shared constants and types for the stream arbiter.
//   DEFAULT_NUM_REQ / DEFAULT_DATA_WIDTH / DEFAULT_TAG_DEPTH : default parameters
//   req_idx_t : requester index / tag, wide enough for the largest supported
//               requester count (8)
package stream_arb_pkg;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_TAG_DEPTH  = 4;

    localparam int MAX_NUM_REQ = 8;
    localparam int REQ_IDX_W   = $clog2(MAX_NUM_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/stream_arbiter_if.sv
// Handshake bundle between the requesters, the shared datapath and the arbiter.
//   req_data / req_valid / req_ready : per-requester request streams
//   dp_in_*                          : arbitrated stream into the datapath
//   dp_out_*                         : datapath result stream
//   rsp_data / rsp_valid / rsp_ready : per-requester result streams
// Modports: slave = arbiter side, master = environment (requesters + datapath).
interface stream_arbiter_if
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_ready;

    logic [DATA_WIDTH-1:0]              dp_in_data;
    logic                               dp_in_valid;
    logic                               dp_in_ready;

    logic [DATA_WIDTH-1:0]              dp_out_data;
    logic                               dp_out_valid;
    logic                               dp_out_ready;

    logic [DATA_WIDTH-1:0]              rsp_data;
    logic [NUM_REQ-1:0]                 rsp_valid;
    logic [NUM_REQ-1:0]                 rsp_ready;

    modport slave (
        input  req_data, req_valid, dp_in_ready, dp_out_data, dp_out_valid, rsp_ready,
        output req_ready, dp_in_data, dp_in_valid, dp_out_ready, rsp_data, rsp_valid
    );

    modport master (
        output req_data, req_valid, dp_in_ready, dp_out_data, dp_out_valid, rsp_ready,
        input  req_ready, dp_in_data, dp_in_valid, dp_out_ready, rsp_data, rsp_valid
    );

endinterface

// File: rtl/stream_arb_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each issued transaction.
//   clk, rst_n       : clock, asynchronous active-low reset
//   push_i/push_tag_i: enqueue a tag (ignored when full)
//   pop_i            : dequeue the head tag (ignored when empty)
//   head_tag_o       : tag at the head (only meaningful when not empty)
//   full_o, empty_o  : occupancy flags
//   count_o          : number of stored tags
module stream_arb_tag_fifo
    import stream_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_TAG_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  req_idx_t               push_tag_i,
    input  logic                   pop_i,
    output req_idx_t               head_tag_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_idx_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_tag_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_tag_i;
    end

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin arbiter sharing one pipelined datapath among NUM_REQ requesters,
// routing results back in order using a tag FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : handshake bundle (stream_arbiter_if.slave)
//   outstanding : issued but not yet returned transactions
//   orphan_err  : sticky, a result arrived while no tag was outstanding
//   grant_cnt   : per-requester acceptance counters (16 bit, wrapping)
// Optional feature: define STREAM_ARB_STATS_EN to build the grant counters;
// otherwise grant_cnt is tied to zero.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TAG_DEPTH  = DEFAULT_TAG_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    stream_arbiter_if.slave              bus,
    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         orphan_err,
    output logic [NUM_REQ-1:0][15:0]     grant_cnt
);

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    req_idx_t               last_grant_q, last_grant_d;
    req_idx_t               winner;
    logic                   any_valid;
    logic                   can_accept;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  win_data;
    logic [NUM_REQ-1:0]     req_ready;

    logic [DATA_WIDTH-1:0]  dp_in_data_q, dp_in_data_d;
    logic                   dp_in_valid_q, dp_in_valid_d;

    req_idx_t               head_tag;
    logic                   fifo_full, fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic                   head_ready;
    logic                   dp_out_ready;
    logic                   pop;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic                   orphan_q, orphan_d;

    // Round-robin search from last_grant+1. Iterating the offset downwards lets
    // the closest valid requester make the final (winning) assignment.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(last_grant_q) + k) % NUM_REQ && bus.req_valid[i]) begin
                    winner    = req_idx_t'(i);
                    any_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == req_idx_t'(i)) win_data = bus.req_data[i];
        end
    end

    // rst_n gates the ready so nothing looks acceptable while reset is held.
    // Fullness uses the pre-pop count: a slot freed this cycle is usable next cycle.
    assign can_accept = rst_n && !fifo_full && (!dp_in_valid_q || bus.dp_in_ready);
    assign accept     = can_accept && any_valid;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (winner == req_idx_t'(i));
        end
    end

    always_comb begin
        dp_in_valid_d = dp_in_valid_q;
        dp_in_data_d  = dp_in_data_q;
        last_grant_d  = last_grant_q;
        if (accept) begin
            dp_in_valid_d = 1'b1;
            dp_in_data_d  = win_data;
            last_grant_d  = winner;
        end else if (bus.dp_in_ready) begin
            dp_in_valid_d = 1'b0;
        end
    end

    stream_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (accept),
        .push_tag_i (winner),
        .pop_i      (pop),
        .head_tag_o (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_comb begin
        rsp_valid  = '0;
        head_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (head_tag == req_idx_t'(i)) begin
                rsp_valid[i] = !fifo_empty && bus.dp_out_valid;
                head_ready   = bus.rsp_ready[i];
            end
        end
    end

    assign dp_out_ready = !fifo_empty && head_ready;
    assign pop          = bus.dp_out_valid && dp_out_ready;
    assign orphan_d     = orphan_q || (bus.dp_out_valid && fifo_empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_in_valid_q <= 1'b0;
            dp_in_data_q  <= '0;
            last_grant_q  <= req_idx_t'(NUM_REQ - 1);
            orphan_q      <= 1'b0;
        end else begin
            dp_in_valid_q <= dp_in_valid_d;
            dp_in_data_q  <= dp_in_data_d;
            last_grant_q  <= last_grant_d;
            orphan_q      <= orphan_d;
        end
    end

`ifdef STREAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && winner == req_idx_t'(i)) grant_cnt_d[i] = grant_cnt_q[i] + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_cnt_q <= '0;
        else        grant_cnt_q <= grant_cnt_d;
    end

    assign grant_cnt = grant_cnt_q;
`else
    assign grant_cnt = '0;
`endif

    assign bus.req_ready    = req_ready;
    assign bus.dp_in_valid  = dp_in_valid_q;
    assign bus.dp_in_data   = dp_in_data_q;
    assign bus.dp_out_ready = dp_out_ready;
    assign bus.rsp_valid    = rsp_valid;
    assign bus.rsp_data     = bus.dp_out_data;
    assign outstanding      = fifo_count;
    assign orphan_err       = orphan_q;

endmodule

// File: tb/tb_stream_arbiter.sv
module tb_stream_arbiter;
    import stream_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int TD = 4;

`ifdef STREAM_ARB_STATS_EN
    localparam logic [63:0] EXP_GC4 = 64'h0001_0001_0001_0001;
`else
    localparam logic [63:0] EXP_GC4 = 64'h0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic [$clog2(TD):0]     outstanding;
    logic                    orphan_err;
    logic [NR-1:0][15:0]     grant_cnt;

    stream_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    stream_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .outstanding (outstanding),
        .orphan_err  (orphan_err),
        .grant_cnt   (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Datapath stand-in: either an auto "+1 with one cycle latency" pipe or
    // directly driven result stream.
    logic          dp_auto;
    logic          man_out_valid;
    logic [DW-1:0] man_out_data;
    logic [DW-1:0] mdl_mem [8];
    logic [2:0]    mdl_wp, mdl_rp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_wp <= 3'd0;
            mdl_rp <= 3'd0;
        end else if (dp_auto) begin
            if (bus.dp_in_valid && bus.dp_in_ready) begin
                mdl_mem[mdl_wp] <= bus.dp_in_data + 16'd1;
                mdl_wp          <= mdl_wp + 3'd1;
            end
            if (bus.dp_out_valid && bus.dp_out_ready) mdl_rp <= mdl_rp + 3'd1;
        end
    end

    assign bus.dp_out_valid = dp_auto ? (mdl_wp != mdl_rp) : man_out_valid;
    assign bus.dp_out_data  = dp_auto ? mdl_mem[mdl_rp] : man_out_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20; n++) begin
            if (outstanding == 0 && !bus.dp_in_valid) break;
            tick();
        end
        chk(tag, 64'({outstanding, bus.dp_in_valid}), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        dp_auto       = 1'b0;
        man_out_valid = 1'b0;
        man_out_data  = '0;
        bus.req_data  = '0;
        bus.req_valid = 4'b1111;
        bus.dp_in_ready = 1'b1;
        bus.rsp_ready = 4'b1111;

        // Reset state (requests already pending must not be acknowledged)
        #1;
        chk("rst_dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
        chk("rst_dp_in_data",  64'(bus.dp_in_data), 64'd0);
        chk("rst_req_ready",   64'(bus.req_ready), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_orphan",      64'(orphan_err), 64'd0);
        chk("rst_grant_cnt",   64'(grant_cnt), 64'd0);
        chk("rst_rsp_valid",   64'(bus.rsp_valid), 64'd0);

        tick();
        tick();
        tick();
        rst_n   = 1'b1;
        dp_auto = 1'b1;
        bus.req_data[0] = 16'h1000;
        bus.req_data[1] = 16'h2000;
        bus.req_data[2] = 16'h3000;
        bus.req_data[3] = 16'h4000;

        // Round-robin with all requesters active
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) chk("gc_after_4", 64'(grant_cnt), EXP_GC4);
            chk("rr_grant", 64'(bus.req_ready), 64'd1 << (k % 4));
            tick();
        end
        bus.req_valid = 4'b0000;
        drain("drain_rr");
        dp_auto = 1'b0;

        // Single request, 1-cycle issue latency and tag routing of the result
        bus.req_valid   = 4'b0100;
        bus.req_data[2] = 16'h00FF;
        #1;
        chk("b_req_ready", 64'(bus.req_ready), 64'h4);
        chk("b_pre_valid", 64'(bus.dp_in_valid), 64'd0);
        tick();
        bus.req_valid = 4'b0000;
        chk("b_dp_in", 64'({bus.dp_in_valid, bus.dp_in_data}), 64'h1_00FF);
        chk("b_outst", 64'(outstanding), 64'd1);
        tick();
        man_out_valid = 1'b1;
        man_out_data  = 16'h0100;
        bus.rsp_ready = 4'b1011;
        #1;
        chk("b_rsp_valid", 64'(bus.rsp_valid), 64'h4);
        chk("b_rsp_data",  64'(bus.rsp_data), 64'h0100);
        chk("b_out_rdy_lo", 64'(bus.dp_out_ready), 64'd0);
        bus.rsp_ready = 4'b0100;
        #1;
        chk("b_out_rdy_hi", 64'(bus.dp_out_ready), 64'd1);
        tick();
        man_out_valid = 1'b0;
        bus.rsp_ready = 4'b1111;
        #1;
        chk("b_outst_0", 64'(outstanding), 64'd0);

        // Tag FIFO full: exactly TAG_DEPTH accepts, pop frees a slot next cycle
        bus.req_valid   = 4'b0001;
        bus.req_data[0] = 16'h0011;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("c_fill_ready", 64'(bus.req_ready), (k < 4) ? 64'd1 : 64'd0);
            @(posedge clk);
        end
        #1;
        chk("c_full_outst", 64'(outstanding), 64'd4);
        man_out_valid = 1'b1;
        #1;
        chk("c_pop_rsp", 64'(bus.rsp_valid), 64'h1);
        chk("c_pop_cycle_ready", 64'(bus.req_ready), 64'd0);
        tick();
        man_out_valid = 1'b0;
        #1;
        chk("c_after_pop_ready", 64'(bus.req_ready), 64'd1);
        chk("c_after_pop_outst", 64'(outstanding), 64'd3);
        tick();
        chk("c_refill_outst", 64'(outstanding), 64'd4);
        chk("c_refill_ready", 64'(bus.req_ready), 64'd0);
        bus.req_valid = 4'b0000;
        man_out_valid = 1'b1;
        drain("drain_full");
        man_out_valid = 1'b0;

        // Backpressure on dp_in
        bus.dp_in_ready = 1'b0;
        bus.req_valid   = 4'b0010;
        bus.req_data[1] = 16'hABCD;
        #1;
        chk("d_first_ready", 64'(bus.req_ready), 64'h2);
        tick();
        bus.req_data[1] = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("d_hold_data", 64'({bus.dp_in_valid, bus.dp_in_data}), 64'h1_ABCD);
            chk("d_hold_ready", 64'(bus.req_ready), 64'd0);
            @(posedge clk);
        end
        #1;
        bus.dp_in_ready = 1'b1;
        #1;
        chk("d_release_ready", 64'(bus.req_ready), 64'h2);
        tick();
        chk("d_next_data", 64'({bus.dp_in_valid, bus.dp_in_data}), 64'h1_1234);
        bus.req_valid = 4'b0000;
        man_out_valid = 1'b1;
        drain("drain_bp");
        man_out_valid = 1'b0;

        // Orphan result
        man_out_valid = 1'b1;
        man_out_data  = 16'h5555;
        #1;
        chk("e_out_ready", 64'(bus.dp_out_ready), 64'd0);
        chk("e_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("e_orphan_pre", 64'(orphan_err), 64'd0);
        tick();
        man_out_valid = 1'b0;
        chk("e_orphan_set", 64'(orphan_err), 64'd1);
        tick();
        tick();
        chk("e_orphan_sticky", 64'(orphan_err), 64'd1);

        // Asynchronous reset with transactions in flight
        bus.req_valid   = 4'b0010;
        bus.req_data[0] = 16'h0A0A;
        tick();
        tick();
        tick();
        bus.req_valid = 4'b0000;
        chk("f_pre_outst", 64'(outstanding), 64'd3);
        chk("f_pre_valid", 64'(bus.dp_in_valid), 64'd1);
        #2;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("f_rst_outst", 64'(outstanding), 64'd0);
        chk("f_rst_valid", 64'(bus.dp_in_valid), 64'd0);
        chk("f_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("f_rst_orphan", 64'(orphan_err), 64'd0);
        chk("f_rst_gc", 64'(grant_cnt), 64'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("f_first_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 4'b0000;
        chk("f_first_data", 64'({bus.dp_in_valid, bus.dp_in_data}), 64'h1_0A0A);
        chk("f_first_outst", 64'(outstanding), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4, number of requester streams sharing one increment datapath (2..8).
- REQ-002: Parameter DATA_WIDTH, default 16, stream payload width in bits.
- REQ-003: Parameter TAG_DEPTH, default 4, maximum outstanding transactions; power of two, at least 2.
- REQ-004: clk  input  1  single clock; all logic on its rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: req_data  input  NUM_REQ x DATA_WIDTH  per-requester payload.
- REQ-007: req_valid / req_ready  input / output  NUM_REQ  per-requester handshake.
- REQ-008: dp_in_data / dp_in_valid  output  DATA_WIDTH / 1  stream into the datapath.
- REQ-009: dp_in_ready  input  1  datapath accept.
- REQ-010: dp_out_data / dp_out_valid  input  DATA_WIDTH / 1  datapath result stream.
- REQ-011: dp_out_ready  output  1  result accept.
- REQ-012: rsp_data  output  DATA_WIDTH  equals dp_out_data, shared by all requesters.
- REQ-013: rsp_valid / rsp_ready  output / input  NUM_REQ  per-requester result handshake.
- REQ-014: outstanding  output  clog2(TAG_DEPTH)+1  count of issued, unreturned transactions.
- REQ-015: orphan_err  output  1  sticky: a result arrived with no outstanding tag.
- REQ-016: grant_cnt  output  NUM_REQ x 16  per-requester accepted-request counters.

Function
- REQ-017: Transfer on any stream SHALL occur when valid and ready are both high on a rising clk edge.
- REQ-018: Arbitration SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; the first requester with req_valid high wins.
- REQ-019: req_ready[i] SHALL be high only for the winner, and only when the output register is empty or draining (dp_in_ready high) and outstanding < TAG_DEPTH.
- REQ-020: A request accepted in cycle N SHALL appear registered on dp_in_data/dp_in_valid in cycle N+1, payload unmodified.
- REQ-021: dp_in_valid SHALL remain high with dp_in_data stable until dp_in_ready is sampled high.
- REQ-022: On acceptance, the winner index SHALL be pushed into an in-order tag FIFO and last_grant updated; outstanding increments.
- REQ-023: rsp_valid[head tag] SHALL equal dp_out_valid; all other rsp_valid bits stay low; dp_out_ready = rsp_ready[head tag] when the FIFO is non-empty.
- REQ-024: On a dp_out handshake the head tag SHALL pop and outstanding decrements; simultaneous push and pop leaves outstanding unchanged.
- REQ-025: When outstanding = TAG_DEPTH, no request SHALL be accepted, including in a cycle where a pop occurs (pop frees the slot for the next cycle).
- REQ-026: dp_out_valid with an empty FIFO SHALL hold dp_out_ready low, set orphan_err, and assert no rsp_valid bit.
- REQ-027: Without contention, one requester holding req_valid high SHALL be accepted every cycle while dp_in_ready stays high.

Reset
- REQ-028: While rst_n is low: dp_in_valid=0, dp_in_data=0, all req_ready=0, tag FIFO empty, outstanding=0, orphan_err=0, grant_cnt=0, last_grant=NUM_REQ-1 so requester 0 has first priority.
- REQ-029: A reset asserted mid-operation SHALL discard in-flight tags and the output register immediately, without waiting for the clock.

Configuration
- REQ-030: Macro STREAM_ARB_STATS_EN defined: grant_cnt[i] increments on each acceptance from requester i and wraps 0xFFFF->0.
- REQ-031: Macro STREAM_ARB_STATS_EN undefined: grant_cnt is driven to constant 0, no counter flops are built, and all other behaviour is unchanged.

Structure
- REQ-032: Package stream_arb_pkg SHALL hold the default constants (NUM_REQ, DATA_WIDTH, TAG_DEPTH) and the index typedef req_idx_t.
- REQ-033: The tag FIFO SHALL be a sub-module stream_arb_tag_fifo (push/pop/full/empty/count).

Verification
- REQ-034: Reset, then req_valid=4'b1111 with dp_in_ready=1 and results returned promptly -> grants in order 0,1,2,3,0,...; grant_cnt = 1 each after 4 accepts.
- REQ-035: Requester 2 sends 0x00FF, datapath returns 0x0100 -> rsp_valid=4'b0100 with rsp_data=0x0100; the accept-to-dp_in_valid delay is 1 cycle.
- REQ-036: dp_out held idle, requester 0 streaming -> exactly 4 accepts, then req_ready low; one result pop -> one more accept on the following cycle.
- REQ-037: dp_in_ready low for 3 cycles -> dp_in_data stable and no new req_ready until it rises.
- REQ-038: dp_out_valid=1 with outstanding=0 -> orphan_err=1 and sticky until rst_n goes low.
- REQ-039: rst_n pulsed low with 3 outstanding -> outstanding=0 and dp_in_valid=0 without a clock edge; the first grant after reset goes to requester 0.
